// File: rtl/tex_pkg.sv
// tex_pkg: texture loader state encoding, texture lengths and default source addresses
package tex_pkg;
  typedef enum logic [2:0] {IDLE, REQ_BIRD, LOAD_BIRD, REQ_PIPE, LOAD_PIPE, REQ_BASE, LOAD_BASE, FINISH} state_t;
  localparam logic [13:0] BIRD_LEN = 14'd5250;
  localparam logic [13:0] PIPE_LEN = 14'd4000;
  localparam logic [13:0] BASE_LEN = 14'd9600;
  localparam logic [23:0] BIRD_SRC_DEF = 24'h000000;
  localparam logic [23:0] PIPE_SRC_DEF = 24'h001800;
  localparam logic [23:0] BASE_SRC_DEF = 24'h002800;
endpackage

// File: rtl/texture_loader_if.sv
// texture_loader_if: burst read channel between the loader and the source memory controller
interface texture_loader_if;
  logic req, ack, valid;
  logic [23:0] addr;
  logic [13:0] len;
  logic [15:0] data;
  modport master(output req, addr, len, input ack, valid, data);
  modport slave(input req, addr, len, output ack, valid, data);
endinterface

// File: rtl/tex_burst_ctr.sv
// tex_burst_ctr: request/ack handshake, word counter and last-word detect shared by all textures
module tex_burst_ctr (
  input  logic        bird_load_clk,
  input  logic        rst_n,
  input  logic        req_st,
  input  logic        ld_st,
  input  logic        ack,
  input  logic        valid,
  input  logic [13:0] len,
  output logic        fire,
  output logic        acc,
  output logic        last,
  output logic [13:0] cnt
);
  assign fire = req_st & ack;
  assign acc  = ld_st & valid;
  assign last = acc & (cnt == len - 14'd1);
  // wrap on the last word so the counter never holds len
  always_ff @(posedge bird_load_clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (req_st) cnt <= '0;
    else if (acc) cnt <= last ? '0 : cnt + 14'd1;
endmodule

// File: rtl/texture_loader.sv
// texture_loader: streams bird, pipe and ground textures from memory into their RAMs
// Optional idle timeout with error flag enabled by TEX_LOADER_TIMEOUT_EN.
module texture_loader import tex_pkg::*; #(
  parameter logic [23:0] BIRD_SRC = BIRD_SRC_DEF,
  parameter logic [23:0] PIPE_SRC = PIPE_SRC_DEF,
  parameter logic [23:0] BASE_SRC = BASE_SRC_DEF,
  parameter logic [15:0] TIMEOUT  = 16'd4096
) (
  input  logic              bird_load_clk,
  input  logic              rst_n,
  input  logic              start,
  texture_loader_if.master  rd,
  output logic              bird_load_en,
  output logic [12:0]       bird_load_addr,
  output logic [15:0]       bird_load_data,
  output logic              pipe_load_en,
  output logic [15:0]       pipe_load_addr,
  output logic              base_load_en,
  output logic [13:0]       base_load_addr,
  output logic              busy,
  output logic              done,
  output logic              error
);
  state_t state, nxt;
  logic req_st, ld_st, fire, acc, last, to;
  logic [1:0] tex;
  logic [13:0] len, cnt;
  assign req_st  = state inside {REQ_BIRD, REQ_PIPE, REQ_BASE};
  assign ld_st   = state inside {LOAD_BIRD, LOAD_PIPE, LOAD_BASE};
  assign tex     = (state inside {REQ_PIPE, LOAD_PIPE}) ? 2'd1 : (state inside {REQ_BASE, LOAD_BASE}) ? 2'd2 : 2'd0;
  assign len     = tex == 2'd1 ? PIPE_LEN : tex == 2'd2 ? BASE_LEN : BIRD_LEN;
  assign rd.req  = req_st;
  assign rd.addr = !req_st ? '0 : tex == 2'd1 ? PIPE_SRC : tex == 2'd2 ? BASE_SRC : BIRD_SRC;
  assign rd.len  = req_st ? len : '0;
  assign busy    = state != IDLE;
  tex_burst_ctr u_ctr (
    .bird_load_clk, .rst_n, .req_st, .ld_st, .ack(rd.ack), .valid(rd.valid), .len,
    .fire, .acc, .last, .cnt
  );
  always_ff @(posedge bird_load_clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  // states are ordered so every handshake step is a +1, and FINISH wraps to IDLE
  always_comb begin
    nxt = state;
    if (state == IDLE) nxt = start ? REQ_BIRD : IDLE;
    else if (fire || last || state == FINISH) nxt = state_t'(state + 3'd1);
    if (to) nxt = FINISH;
  end
  always_ff @(posedge bird_load_clk or negedge rst_n)
    if (!rst_n) begin
      bird_load_en   <= 1'b0;
      pipe_load_en   <= 1'b0;
      base_load_en   <= 1'b0;
      bird_load_addr <= '0;
      pipe_load_addr <= '0;
      base_load_addr <= '0;
      bird_load_data <= '0;
      done           <= 1'b0;
    end else begin
      bird_load_en <= acc && tex == 2'd0;
      pipe_load_en <= acc && tex == 2'd1;
      base_load_en <= acc && tex == 2'd2;
      if (acc) bird_load_data <= rd.data;
      if (acc && tex == 2'd0) bird_load_addr <= cnt[12:0];
      if (acc && tex == 2'd1) pipe_load_addr <= {2'b00, cnt};
      if (acc && tex == 2'd2) base_load_addr <= cnt;
      done <= state == FINISH;
    end
`ifdef TEX_LOADER_TIMEOUT_EN
  logic [15:0] idle;
  assign to = (req_st || ld_st) && !rd.ack && !rd.valid && idle == TIMEOUT - 16'd1;
  always_ff @(posedge bird_load_clk or negedge rst_n)
    if (!rst_n) begin
      idle  <= '0;
      error <= 1'b0;
    end else begin
      idle  <= (!(req_st || ld_st) || rd.ack || rd.valid) ? '0 : idle + 16'd1;
      error <= to ? 1'b1 : (state == IDLE && start) ? 1'b0 : error;
    end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign to    = 1'b0;
  assign error = 1'b0;
`endif
endmodule

// File: tb/tb_texture_loader.sv
// tb_texture_loader: directed table-driven bench for texture_loader
module tb_texture_loader;
  typedef struct {
    logic [23:0] src;
    int          len;
  } burst_t;
  burst_t tab[3];
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic bird_en, pipe_en, base_en, busy, done, error;
  logic [12:0] bird_addr;
  logic [15:0] pipe_addr, data;
  logic [13:0] base_addr;
  int ncmp = 0, nerr = 0;
  int nb, np, ns, ovl, bad, ndone, bdbad, errseen;
  logic pbusy = 1'b0;
  logic [15:0] la[3], ld[3];
  always #10 clk = ~clk;
  texture_loader_if rd();
  texture_loader dut (
    .bird_load_clk(clk), .rst_n(rst_n), .start(start), .rd(rd),
    .bird_load_en(bird_en), .bird_load_addr(bird_addr), .bird_load_data(data),
    .pipe_load_en(pipe_en), .pipe_load_addr(pipe_addr),
    .base_load_en(base_en), .base_load_addr(base_addr),
    .busy(busy), .done(done), .error(error)
  );
  // strobe monitor: each texture must see addr = data = running word index
  always @(posedge clk) begin
    #5;
    if (bird_en) begin
      if (bird_addr !== nb[12:0] || data !== nb[15:0]) bad++;
      la[0] = 16'(bird_addr); ld[0] = data; nb++;
    end
    if (pipe_en) begin
      if (pipe_addr !== np[15:0] || data !== np[15:0]) bad++;
      la[1] = pipe_addr; ld[1] = data; np++;
    end
    if (base_en) begin
      if (base_addr !== ns[13:0] || data !== ns[15:0]) bad++;
      la[2] = 16'(base_addr); ld[2] = data; ns++;
    end
    if ($countones({bird_en, pipe_en, base_en}) > 1) ovl++;
    if (done) begin
      ndone++;
      if (busy || !pbusy) bdbad++;
    end
    if (error) errseen++;
    pbusy = busy;
  end
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    ncmp++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask
  task automatic clr();
    nb = 0; np = 0; ns = 0; ovl = 0; bad = 0; ndone = 0; bdbad = 0;
  endtask
  task automatic all_zero(input string tag);
    chk({tag, "_rd_req"}, 32'(rd.req), 0);
    chk({tag, "_rd_addr"}, 32'(rd.addr), 0);
    chk({tag, "_rd_len"}, 32'(rd.len), 0);
    chk({tag, "_bird_en"}, 32'(bird_en), 0);
    chk({tag, "_bird_addr"}, 32'(bird_addr), 0);
    chk({tag, "_data"}, 32'(data), 0);
    chk({tag, "_pipe_en"}, 32'(pipe_en), 0);
    chk({tag, "_pipe_addr"}, 32'(pipe_addr), 0);
    chk({tag, "_base_en"}, 32'(base_en), 0);
    chk({tag, "_base_addr"}, 32'(base_addr), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_error"}, 32'(error), 0);
  endtask
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic wait_req(input int k);
    int w = 0;
    while (!rd.req && w < 50) begin @(negedge clk); w++; end
    chk($sformatf("req_seen%0d", k), 32'(rd.req), 1);
    chk($sformatf("rd_addr%0d", k), 32'(rd.addr), 32'(tab[k].src));
    chk($sformatf("rd_len%0d", k), 32'(rd.len), 32'(tab[k].len));
  endtask
  task automatic burst(input int k, input int nw, input bit gap, input bit poke);
    int c;
    wait_req(k);
    repeat (3) @(negedge clk);
    chk($sformatf("req_hold%0d", k), 32'(rd.req), 1);
    rd.ack = 1'b1;
    @(negedge clk);
    rd.ack = 1'b0;
    chk($sformatf("req_drop%0d", k), 32'(rd.req), 0);
    for (int i = 0; i < nw; i++) begin
      rd.valid = 1'b1; rd.data = i[15:0]; start = poke && i == 100;
      @(negedge clk);
      start = 1'b0;
      if (gap) begin rd.valid = 1'b0; @(negedge clk); end
    end
    rd.valid = 1'b0;
    if (nw == tab[k].len) begin
      rd.valid = 1'b1; rd.data = 16'hdead;
      repeat (2) @(negedge clk);
      rd.valid = 1'b0;
      @(negedge clk);
      c = k == 0 ? nb : k == 1 ? np : ns;
      chk($sformatf("strobes%0d", k), 32'(c), 32'(tab[k].len));
      chk($sformatf("last_addr%0d", k), 32'(la[k]), 32'(tab[k].len - 1));
      chk($sformatf("last_data%0d", k), 32'(ld[k]), 32'(tab[k].len - 1));
    end
  endtask
  task automatic run_seq(input bit gap, input bit poke);
    clr();
    pulse_start();
    chk("busy_after_start", 32'(busy), 1);
    for (int k = 0; k < 3; k++) burst(k, tab[k].len, gap, poke && k == 1);
    repeat (3) @(negedge clk);
    chk("done_count", 32'(ndone), 1);
    chk("busy_end", 32'(busy), 0);
    chk("overlap", 32'(ovl), 0);
    chk("addr_data_order", 32'(bad), 0);
    chk("busy_done_edge", 32'(bdbad), 0);
  endtask
  initial begin
    tab[0] = '{24'h000000, 5250};
    tab[1] = '{24'h001800, 4000};
    tab[2] = '{24'h002800, 9600};
    errseen = 0;
    rd.ack = 1'b0; rd.valid = 1'b0; rd.data = '0;
    repeat (2) @(negedge clk);
    all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 0);
    run_seq(1'b0, 1'b0);
    chk("bird_final_data", 32'(ld[0]), 32'h1481);
    run_seq(1'b1, 1'b1);
    clr();
    pulse_start();
    burst(0, tab[0].len, 1'b0, 1'b0);
    burst(1, tab[1].len, 1'b0, 1'b0);
    burst(2, 2000, 1'b0, 1'b0);
    rd.valid = 1'b1; rd.data = 16'd2000;
    rst_n = 1'b0;
    #1;
    all_zero("mid_reset");
    repeat (3) @(negedge clk);
    chk("base_strobes_at_reset", 32'(ns), 2000);
    rd.valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    pulse_start();
    wait_req(0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
`ifdef TEX_LOADER_TIMEOUT_EN
    begin
      int w = 0;
      clr();
      pulse_start();
      burst(0, 10, 1'b0, 1'b0);
      while (ndone == 0 && w < 5000) begin @(negedge clk); w++; end
      chk("timeout_done", 32'(ndone), 1);
      chk("timeout_error", 32'(error), 1);
      chk("timeout_idle", 32'(busy), 0);
      chk("timeout_words", 32'(nb), 10);
      pulse_start();
      chk("error_cleared", 32'(error), 0);
      chk("restart_busy", 32'(busy), 1);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
    end
`else
    chk("error_never_set", 32'(errseen), 0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
